stack_controller: RTL

STACK_CONTROLLER -- requirements
Module: stack_controller

---
 rtl/stack_controller.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/stack_controller.sv
// Multicycle control unit for a small stack machine.
// Moore FSM: every control output is a pure decode of the current state
// (plus the opcode latched in DECODE). The opcode input is looked at only
// in DECODE; later states use the latched copy, so the instruction
// register may change freely after decode without disturbing the sequence.
module stack_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] OPC,
    output logic       IorD,
    output logic       memRead,
    output logic       memWrite,
    output logic       IRWrite,
    output logic       SrcA,
    output logic       SrcB,
    output logic       LdA,
    output logic       LdB,
    output logic       PCWrite,
    output logic       PCSrc,
    output logic       tos,
    output logic       Push,
    output logic       Pop,
    output logic       PCWriteCond,
    output logic       MtoS,
    output logic [1:0] AluOP,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_POPA   = 4'd3,
        ST_POPB   = 4'd4,
        ST_EXEC   = 4'd5,
        ST_WB     = 4'd6,
        ST_PSHRD  = 4'd7,
        ST_PSHWR  = 4'd8,
        ST_POPRD  = 4'd9,
        ST_POPWR  = 4'd10,
        ST_JMP    = 4'd11,
        ST_JZTOS  = 4'd12,
        ST_JZBR   = 4'd13
    } state_t;

    // Opcode values
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_NOT  = 3'b011;
    localparam logic [2:0] OP_PUSH = 3'b100;
    localparam logic [2:0] OP_POP  = 3'b101;
    localparam logic [2:0] OP_JMP  = 3'b110;
    localparam logic [2:0] OP_JZ   = 3'b111;

    // The state register is a plain 4-bit vector so that the two unused
    // encodings (14, 15) are representable and can be recovered from.
    logic [3:0] state_reg;
    logic [3:0] state_next;
    logic [2:0] opc_reg;
    logic [2:0] opc_next;

    // State and latched-opcode registers; reset aborts any instruction at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            opc_reg   <= OP_ADD;
        end else begin
            state_reg <= state_next;
            opc_reg   <= opc_next;
        end
    end

    // Opcode latch: capture OPC only while decoding, hold it otherwise.
    always_comb begin
        opc_next = opc_reg;
        if (state_reg == ST_DECODE) begin
            opc_next = OPC;
        end
    end

    // Next-state logic; unknown encodings fall back to IDLE.
    always_comb begin
        state_next = ST_IDLE;
        case (state_reg)
            ST_IDLE:   state_next = ST_FETCH;
            ST_FETCH:  state_next = ST_DECODE;
            ST_DECODE: begin
                case (OPC)
                    OP_ADD,
                    OP_SUB,
                    OP_AND,
                    OP_NOT:  state_next = ST_POPA;
                    OP_PUSH: state_next = ST_PSHRD;
                    OP_POP:  state_next = ST_POPRD;
                    OP_JMP:  state_next = ST_JMP;
                    OP_JZ:   state_next = ST_JZTOS;
                    default: state_next = ST_IDLE;
                endcase
            end
            // NOT is unary: skip the second operand pop.
            ST_POPA:   state_next = (opc_reg == OP_NOT) ? ST_EXEC : ST_POPB;
            ST_POPB:   state_next = ST_EXEC;
            ST_EXEC:   state_next = ST_WB;
            ST_WB:     state_next = ST_FETCH;
            ST_PSHRD:  state_next = ST_PSHWR;
            ST_PSHWR:  state_next = ST_FETCH;
            ST_POPRD:  state_next = ST_POPWR;
            ST_POPWR:  state_next = ST_FETCH;
            ST_JMP:    state_next = ST_FETCH;
            ST_JZTOS:  state_next = ST_JZBR;
            ST_JZBR:   state_next = ST_FETCH;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Moore output decode: everything defaults low, each state raises its own set.
    always_comb begin
        IorD        = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        IRWrite     = 1'b0;
        SrcA        = 1'b0;
        SrcB        = 1'b0;
        LdA         = 1'b0;
        LdB         = 1'b0;
        PCWrite     = 1'b0;
        PCSrc       = 1'b0;
        tos         = 1'b0;
        Push        = 1'b0;
        Pop         = 1'b0;
        PCWriteCond = 1'b0;
        MtoS        = 1'b0;
        AluOP       = 2'b00;
        case (state_reg)
            ST_FETCH: begin
                // IR <= mem[PC]; PC <= PC + 1 through the ALU (ADD, PC, 1)
                memRead = 1'b1;
                IRWrite = 1'b1;
                SrcA    = 1'b1;
                SrcB    = 1'b1;
                PCWrite = 1'b1;
            end
            ST_POPA: begin
                Pop = 1'b1;
                LdA = 1'b1;
            end
            ST_POPB: begin
                Pop = 1'b1;
                LdB = 1'b1;
            end
            ST_EXEC: begin
                // A op B (or NOT A); the low opcode bits are the ALU function
                AluOP = opc_reg[1:0];
            end
            ST_WB: begin
                Push = 1'b1;
            end
            ST_PSHRD: begin
                // MDR <= mem[IR[4:0]]
                memRead = 1'b1;
                IorD    = 1'b1;
            end
            ST_PSHWR: begin
                Push = 1'b1;
                MtoS = 1'b1;
            end
            ST_POPRD: begin
                Pop = 1'b1;
                LdA = 1'b1;
            end
            ST_POPWR: begin
                // mem[IR[4:0]] <= A
                memWrite = 1'b1;
                IorD     = 1'b1;
            end
            ST_JMP: begin
                PCWrite = 1'b1;
                PCSrc   = 1'b1;
            end
            ST_JZTOS: begin
                // Peek the stack top into Z without popping
                tos = 1'b1;
            end
            ST_JZBR: begin
                PCWriteCond = 1'b1;
                PCSrc       = 1'b1;
            end
            default: begin
                // IDLE, DECODE and unused encodings drive nothing
            end
        endcase
    end

    assign state = state_reg;

endmodule
